// File: rtl/ascon_pack.sv
// Shared types and constants for the ASCON permutation engine.
package ascon_pack;

    // Full 320-bit ASCON state: x0 = [319:256] ... x4 = [63:0].
    typedef logic [319:0] type_state;

    // Total number of rounds in the full permutation.
    localparam int NB_ROUNDS = 12;

    // Permutation flavour: p12 runs rounds 0..11, p6 runs rounds 6..11.
    typedef enum logic {
        P12 = 1'b0,
        P6  = 1'b1
    } ascon_mode_e;

    // Round constant c_r = {15-r, r}, added into the low byte of x2.
    localparam logic [7:0] ROUND_CONST [NB_ROUNDS] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // 64-bit rotate right; n is always a constant at the call sites.
    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition, S-box layer, linear layer.
module ascon_round
    import ascon_pack::*;
(
    input  logic [3:0] round_i,
    input  type_state  state_i,
    output type_state  state_o
);

    logic [7:0]  rc;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] s0, s1, s2, s3, s4;

    // Indices past the last round only occur on unused idle lanes; give them a zero constant.
    assign rc = (round_i < 4'(NB_ROUNDS)) ? ROUND_CONST[round_i] : 8'h00;

    assign x0 = state_i[319:256];
    assign x1 = state_i[255:192];
    assign x2 = state_i[191:128] ^ {56'h0, rc};
    assign x3 = state_i[127:64];
    assign x4 = state_i[63:0];

    // Bitsliced 5-bit S-box: input mixing, chi-like core, output mixing.
    assign a0 = x0 ^ x4;
    assign a1 = x1;
    assign a2 = x2 ^ x1;
    assign a3 = x3;
    assign a4 = x4 ^ x3;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign s0 = b0 ^ b4;
    assign s1 = b1 ^ b0;
    assign s2 = ~b2;
    assign s3 = b3 ^ b2;
    assign s4 = b4;

    // Linear diffusion layer, one rotation pair per word.
    assign state_o[319:256] = s0 ^ rotr64(s0, 19) ^ rotr64(s0, 28);
    assign state_o[255:192] = s1 ^ rotr64(s1, 61) ^ rotr64(s1, 39);
    assign state_o[191:128] = s2 ^ rotr64(s2, 1)  ^ rotr64(s2, 6);
    assign state_o[127:64]  = s3 ^ rotr64(s3, 10) ^ rotr64(s3, 17);
    assign state_o[63:0]    = s4 ^ rotr64(s4, 7)  ^ rotr64(s4, 41);

endmodule

// File: rtl/ascon_perm_engine.sv
// Self-sequenced ASCON permutation: runs p12 or p6 from one start pulse,
// UNROLL rounds per clock, with begin/end key/data XORs around the rounds.
//
// Handshake: start_i is sampled only while busy_o=0; the edge that samples it
// also computes the first chunk. busy_o is high while further chunks remain,
// done_o pulses for one cycle with val_o holding the result and busy_o low,
// and a new start_i is accepted in that same done_o cycle.
module ascon_perm_engine
    import ascon_pack::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic         init_i,
    input  type_state    val_i,
    input  logic [63:0]  data_i,
    input  logic [127:0] key_i,
    input  logic         xor_data_i,
    input  logic         xor_key_i,
    input  logic         xor_key_end_i,
    input  logic         xor_dom_end_i,
    output type_state    val_o,
    output logic         busy_o,
    output logic         done_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 6)) begin : g_bad_unroll
        $error("ascon_perm_engine: UNROLL must be 1, 2, 3 or 6");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

    localparam logic [3:0] STEP      = 4'(UNROLL);
    localparam logic [3:0] ROUND_END = 4'(NB_ROUNDS);
    localparam logic [3:0] P6_FIRST  = 4'(NB_ROUNDS / 2);

    fsm_e       fsm;
    logic [3:0] cnt;
    type_state  state;
    logic       key_end_q;
    logic       dom_end_q;

    logic       accept;
    logic       last;
    logic       key_end;
    logic       dom_end;
    logic [3:0] r_base;
    type_state  src;
    type_state  begin_x;
    type_state  end_x;
    logic [UNROLL:0][319:0] chain;

    // Select the round base and source state, and apply the begin-XORs on the accepting edge.
    always_comb begin
        accept  = (fsm == IDLE) && start_i;
        r_base  = cnt;
        if (fsm == IDLE) begin
            r_base = (ascon_mode_e'(mode_i) == P6) ? P6_FIRST : 4'd0;
        end
        src     = (accept && init_i) ? val_i : state;
        begin_x = src;
        if (accept && xor_data_i) begin
            begin_x[319:256] = begin_x[319:256] ^ data_i;
        end
        if (accept && xor_key_i) begin
            begin_x[255:128] = begin_x[255:128] ^ key_i;
        end
    end

    assign chain[0] = begin_x;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        ascon_round u_round (
            .round_i (r_base + 4'(k)),
            .state_i (chain[k]),
            .state_o (chain[k+1])
        );
    end

    // On the final chunk apply the end-XORs; the accepting edge uses the live command bits.
    always_comb begin
        last    = (r_base + STEP) == ROUND_END;
        key_end = accept ? xor_key_end_i : key_end_q;
        dom_end = accept ? xor_dom_end_i : dom_end_q;
        end_x   = chain[UNROLL];
        if (last && key_end) begin
            end_x[127:0] = end_x[127:0] ^ key_i;
        end
        if (last && dom_end) begin
            end_x[0] = ~end_x[0];
        end
    end

    // Sequencer: accept a command, step the round counter, register state, busy and done.
    // The chosen mode survives only as the counter start value.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm       <= IDLE;
            cnt       <= 4'd0;
            state     <= '0;
            key_end_q <= 1'b0;
            dom_end_q <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        state     <= end_x;
                        key_end_q <= xor_key_end_i;
                        dom_end_q <= xor_dom_end_i;
                        if (last) begin
                            cnt    <= 4'd0;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            cnt    <= r_base + STEP;
                            busy_o <= 1'b1;
                            fsm    <= RUN;
                        end
                    end
                end
                RUN: begin
                    state <= end_x;
                    if (last) begin
                        cnt    <= 4'd0;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        fsm    <= IDLE;
                    end else begin
                        cnt <= cnt + STEP;
                    end
                end
                default: begin
                    fsm    <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign val_o = state;

endmodule

// File: tb/tb_ascon_perm_engine.sv
// Directed bench for ascon_perm_engine at UNROLL = 1, 3 and 6.
module tb_ascon_perm_engine;
    import ascon_pack::*;

    localparam logic [319:0] S0 = {64'h80400c0600000000,
                                   128'h000102030405060708090a0b0c0d0e0f,
                                   128'h000102030405060708090a0b0c0d0e0f};
    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [63:0]  PAD     = 64'h8000000000000000;
    localparam logic [127:0] KAT_TAG = 128'he355159f292911f794cb1432a0103a8a;
    localparam logic [4:0] SBOX_TBL [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic resetb;
    always #5 clock = ~clock;

    logic         start_1, start_3, start_6;
    logic         mode_i, init_i;
    logic [319:0] val_i;
    logic [63:0]  data_i;
    logic [127:0] key_i;
    logic         xor_data_i, xor_key_i, xor_key_end_i, xor_dom_end_i;
    logic [319:0] val_1, val_3, val_6;
    logic         busy_1, busy_3, busy_6;
    logic         done_1, done_3, done_6;

    ascon_perm_engine #(.UNROLL(1)) u_eng1 (
        .clock_i(clock), .resetb_i(resetb), .start_i(start_1), .mode_i(mode_i),
        .init_i(init_i), .val_i(val_i), .data_i(data_i), .key_i(key_i),
        .xor_data_i(xor_data_i), .xor_key_i(xor_key_i), .xor_key_end_i(xor_key_end_i),
        .xor_dom_end_i(xor_dom_end_i), .val_o(val_1), .busy_o(busy_1), .done_o(done_1)
    );
    ascon_perm_engine #(.UNROLL(3)) u_eng3 (
        .clock_i(clock), .resetb_i(resetb), .start_i(start_3), .mode_i(mode_i),
        .init_i(init_i), .val_i(val_i), .data_i(data_i), .key_i(key_i),
        .xor_data_i(xor_data_i), .xor_key_i(xor_key_i), .xor_key_end_i(xor_key_end_i),
        .xor_dom_end_i(xor_dom_end_i), .val_o(val_3), .busy_o(busy_3), .done_o(done_3)
    );
    ascon_perm_engine #(.UNROLL(6)) u_eng6 (
        .clock_i(clock), .resetb_i(resetb), .start_i(start_6), .mode_i(mode_i),
        .init_i(init_i), .val_i(val_i), .data_i(data_i), .key_i(key_i),
        .xor_data_i(xor_data_i), .xor_key_i(xor_key_i), .xor_key_end_i(xor_key_end_i),
        .xor_dom_end_i(xor_dom_end_i), .val_o(val_6), .busy_o(busy_6), .done_o(done_6)
    );

    // ---------------- reference model (table S-box) ----------------
    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x};
        return d[n +: 64];
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int r);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        logic [4:0]  o;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        x[2][7:0] = x[2][7:0] ^ 8'(((15 - r) << 4) | r);
        for (int i = 0; i < 64; i++) begin
            v = {x[0][i], x[1][i], x[2][i], x[3][i], x[4][i]};
            o = SBOX_TBL[v];
            for (int w = 0; w < 5; w++) y[w][i] = o[4 - w];
        end
        x[0] = y[0] ^ ror(y[0], 19) ^ ror(y[0], 28);
        x[1] = y[1] ^ ror(y[1], 61) ^ ror(y[1], 39);
        x[2] = y[2] ^ ror(y[2], 1)  ^ ror(y[2], 6);
        x[3] = y[3] ^ ror(y[3], 10) ^ ror(y[3], 17);
        x[4] = y[4] ^ ror(y[4], 7)  ^ ror(y[4], 41);
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int first);
        logic [319:0] t;
        t = s;
        for (int r = first; r < 12; r++) t = model_round(t, r);
        return t;
    endfunction

    // ---------------- scoreboard ----------------
    logic [319:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [319:0] get_val(input int sel);
        case (sel)
            1: return val_1;
            3: return val_3;
            default: return val_6;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            1: return busy_1;
            3: return busy_3;
            default: return busy_6;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            1: return done_1;
            3: return done_3;
            default: return done_6;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_cmd(input logic init, input logic mode, input logic [319:0] v,
                           input logic xd, input logic xk, input logic xke, input logic xde);
        init_i        = init;
        mode_i        = mode;
        val_i         = v;
        data_i        = PAD;
        key_i         = KEY;
        xor_data_i    = xd;
        xor_key_i     = xk;
        xor_key_end_i = xke;
        xor_dom_end_i = xde;
    endtask

    // Caller raises a start and pushes the expected result; this follows the run to done.
    task automatic run_wait(input string tag, input int sel, input int exp_n);
        logic [319:0] exp_v;
        int k;
        int busy_cnt;
        bit seen;
        exp_v    = exp_q.pop_front();
        k        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clock);
            #1;
            k++;
            start_1 = 1'b0;
            start_3 = 1'b0;
            start_6 = 1'b0;
            if (get_done(sel)) seen = 1'b1;
            else if (get_busy(sel)) busy_cnt++;
        end
        check_eq({tag, "_done_seen"}, 320'(seen), 320'(1));
        check_eq({tag, "_latency"}, 320'(k), 320'(exp_n));
        check_eq({tag, "_busy_cycles"}, 320'(busy_cnt), 320'(exp_n - 1));
        check_eq({tag, "_busy_at_done"}, 320'(get_busy(sel)), 320'(0));
        check_eq({tag, "_val"}, get_val(sel), exp_v);
        @(posedge clock);
        #1;
        check_eq({tag, "_done_pulse"}, 320'(get_done(sel)), 320'(0));
    endtask

    // ---------------- directed sequence ----------------
    logic [319:0] exp_init, exp_p6, exp_n1, exp_a, exp_b, exp_b2b;
    int  k;
    bit  seen;

    initial begin
        resetb  = 1'b0;
        start_1 = 1'b0;
        start_3 = 1'b0;
        start_6 = 1'b0;
        set_cmd(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_val_u1", val_1, '0);
        check_eq("rst_val_u6", val_6, '0);
        check_eq("rst_busy_u1", 320'(busy_1), 320'(0));
        check_eq("rst_done_u1", 320'(done_1), 320'(0));
        check_eq("rst_busy_u3", 320'(busy_3), 320'(0));
        resetb = 1'b1;
        @(posedge clock);
        #1;

        // p12 init with key end-XOR on every unroll
        exp_init = model_perm(S0, 0);
        exp_init[127:0] = exp_init[127:0] ^ KEY;
        set_cmd(1'b1, 1'b0, S0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(exp_init); start_1 = 1'b1; run_wait("init_u1", 1, 12);
        exp_q.push_back(exp_init); start_3 = 1'b1; run_wait("init_u3", 3, 4);
        exp_q.push_back(exp_init); start_6 = 1'b1; run_wait("init_u6", 6, 2);

        // p6 on the internal state with data begin-XOR and domain separation
        exp_p6 = exp_init;
        exp_p6[319:256] = exp_p6[319:256] ^ PAD;
        exp_p6 = model_perm(exp_p6, 6);
        exp_p6[0] = ~exp_p6[0];
        set_cmd(1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(exp_p6); start_1 = 1'b1; run_wait("p6_u1", 1, 6);
        exp_q.push_back(exp_p6); start_3 = 1'b1; run_wait("p6_u3", 3, 2);

        // single-edge permutation: p6 at UNROLL=6
        exp_n1 = model_perm(S0, 6);
        exp_n1[0] = ~exp_n1[0];
        set_cmd(1'b1, 1'b1, S0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_q.push_back(exp_n1); start_6 = 1'b1; run_wait("p6_n1_u6", 6, 1);

        // full ASCON-128 flow for empty AD and plaintext: init, then finalization
        exp_a = model_perm(S0, 0);
        exp_a[127:0] = exp_a[127:0] ^ KEY;
        exp_a[0] = ~exp_a[0];
        set_cmd(1'b1, 1'b0, S0, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(exp_a); start_1 = 1'b1; run_wait("kat_init_u1", 1, 12);
        exp_q.push_back(exp_a); start_6 = 1'b1; run_wait("kat_init_u6", 6, 2);
        exp_b = exp_a;
        exp_b[319:256] = exp_b[319:256] ^ PAD;
        exp_b[255:128] = exp_b[255:128] ^ KEY;
        exp_b = model_perm(exp_b, 0);
        exp_b[127:0] = exp_b[127:0] ^ KEY;
        set_cmd(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(exp_b); start_1 = 1'b1; run_wait("kat_fin_u1", 1, 12);
        check_eq("kat_tag_u1", 320'(val_1[127:0]), 320'(KAT_TAG));
        exp_q.push_back(exp_b); start_6 = 1'b1; run_wait("kat_fin_u6", 6, 2);
        check_eq("kat_tag_u6", 320'(val_6[127:0]), 320'(KAT_TAG));

        // start held high; command changes during busy must be ignored
        set_cmd(1'b1, 1'b0, S0, 1'b0, 1'b0, 1'b1, 1'b0);
        start_1 = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clock);
            #1;
            k++;
            if (k == 1) begin
                val_i         = ~S0;
                mode_i        = 1'b1;
                xor_data_i    = 1'b1;
                xor_dom_end_i = 1'b1;
            end
            if (done_1) seen = 1'b1;
        end
        check_eq("hold_latency", 320'(k), 320'(12));
        check_eq("hold_val", val_1, exp_init);
        // new command in the done cycle, start still high
        set_cmd(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        start_1 = 1'b0;
        check_eq("b2b_accept_busy", 320'(busy_1), 320'(1));
        k = 1;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clock);
            #1;
            k++;
            if (done_1) seen = 1'b1;
        end
        exp_b2b = model_perm(exp_init, 6);
        check_eq("b2b_latency", 320'(k), 320'(6));
        check_eq("b2b_val", val_1, exp_b2b);

        // asynchronous reset in the middle of a p12 run
        @(posedge clock);
        #1;
        set_cmd(1'b1, 1'b0, S0, 1'b0, 1'b0, 1'b1, 1'b0);
        start_1 = 1'b1;
        repeat (5) begin
            @(posedge clock);
            #1;
            start_1 = 1'b0;
        end
        check_eq("rst_mid_busy_before", 320'(busy_1), 320'(1));
        #2;
        resetb = 1'b0;
        #1;
        check_eq("rst_mid_val", val_1, '0);
        check_eq("rst_mid_busy", 320'(busy_1), 320'(0));
        @(posedge clock);
        #3;
        resetb = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (done_1) seen = 1'b1;
        end
        check_eq("rst_mid_no_done", 320'(seen), 320'(0));
        exp_q.push_back(exp_init); start_1 = 1'b1; run_wait("post_rst_u1", 1, 12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
